// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encoding,
// interrupt cause codes, mstatus bit positions and the read-modify-write helper.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam logic [4:0] IRQ_CODE_MSI    = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI    = 5'd7;
    localparam logic [4:0] IRQ_CODE_MEI    = 5'd11;
    localparam logic [4:0] IRQ_CODE_LOCAL0 = 5'd16;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] operand);
        logic [31:0] res;
        case (op)
            CSR_OP_WRITE: res = operand;
            CSR_OP_SET:   res = old_val | operand;
            CSR_OP_CLEAR: res = old_val & ~operand;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with per-half write strobes; a half write replaces the
// increment for that cycle and never carries into the other half.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        inhibit,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_d;
    logic [63:0] count_q;

    // next count: write strobes take precedence over counting
    always_comb begin
        count_d = count_q;
        if (wr_lo) begin
            count_d = {count_q[63:32], wdata};
        end else if (wr_hi) begin
            count_d = {wdata, count_q[31:0]};
        end else if (en && !inhibit) begin
            count_d = count_q + 64'd1;
        end else begin
            count_d = count_q;
        end
    end

    // counter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 64'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSR read/modify/write, trap entry and mret, interrupt
// arbitration with vectored mtvec, and optional mcycle/minstret counters.
module csr_file_m
    import csr_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter bit          HAS_COUNTERS  = 1'b1,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
    parameter logic [31:0] HART_ID       = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [11:0]              csr_addr,
    input  logic [1:0]               csr_op,
    input  logic [31:0]              csr_wdata,
    output logic [31:0]              csr_rdata,
    output logic                     csr_illegal,
    input  logic                     irq_ext,
    input  logic                     irq_timer,
    input  logic                     irq_soft,
    input  logic [NUM_LOCAL_IRQ-1:0] irq_local,
    output logic                     irq_pending,
    output logic [4:0]               irq_code,
    input  logic                     trap_take,
    input  logic                     exc_valid,
    input  logic [4:0]               exc_code,
    input  logic [31:0]              exc_tval,
    input  logic [31:0]              current_pc,
    input  logic                     mret,
    input  logic                     instr_retire,
    output logic [31:0]              trap_vector,
    output logic [31:0]              mepc,
    output logic                     mie_global
);

    localparam logic [31:0] MIE_MASK = 32'h0000_0888 |
                                       ((((32'd1 << NUM_LOCAL_IRQ) - 32'd1) & 32'h0000_FFFF) << 16);

    logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [31:0] mip_q, mip_d, mcountinhibit_q, mcountinhibit_d;
    logic [31:0] mstatus_s, wval_s, pending_s;
    logic [63:0] mcycle_s, minstret_s;
    logic [15:0] local_src_s;
    logic [4:0]  local_code_s, irq_code_s;
    logic        illegal_addr_s, read_only_s, trap_s, csr_we_s, irq_pending_s;

    assign mstatus_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};

    generate
        if (NUM_LOCAL_IRQ > 0) begin : g_local
            assign local_src_s = 16'(irq_local);
        end else begin : g_no_local
            assign local_src_s = 16'd0;
        end
    endgenerate

    // read mux and address legality decode
    always_comb begin
        csr_rdata      = 32'd0;
        illegal_addr_s = 1'b0;
        read_only_s    = 1'b0;
        case (csr_addr)
            CSR_MSTATUS:       csr_rdata = mstatus_s;
            CSR_MISA:          csr_rdata = MISA_VALUE;
            CSR_MIE:           csr_rdata = mie_q;
            CSR_MTVEC:         csr_rdata = mtvec_q;
            CSR_MSCRATCH:      csr_rdata = mscratch_q;
            CSR_MEPC:          csr_rdata = mepc_q;
            CSR_MCAUSE:        csr_rdata = mcause_q;
            CSR_MTVAL:         csr_rdata = mtval_q;
            CSR_MIP:           csr_rdata = mip_q;
            CSR_MCOUNTINHIBIT: begin csr_rdata = HAS_COUNTERS ? mcountinhibit_q : 32'd0; illegal_addr_s = !HAS_COUNTERS; end
            CSR_MCYCLE:        begin csr_rdata = HAS_COUNTERS ? mcycle_s[31:0]    : 32'd0; illegal_addr_s = !HAS_COUNTERS; end
            CSR_MCYCLEH:       begin csr_rdata = HAS_COUNTERS ? mcycle_s[63:32]   : 32'd0; illegal_addr_s = !HAS_COUNTERS; end
            CSR_MINSTRET:      begin csr_rdata = HAS_COUNTERS ? minstret_s[31:0]  : 32'd0; illegal_addr_s = !HAS_COUNTERS; end
            CSR_MINSTRETH:     begin csr_rdata = HAS_COUNTERS ? minstret_s[63:32] : 32'd0; illegal_addr_s = !HAS_COUNTERS; end
            CSR_MHARTID:       begin csr_rdata = HART_ID; read_only_s = 1'b1; end
            default:           illegal_addr_s = 1'b1;
        endcase
    end

    assign csr_illegal = (csr_op != CSR_OP_NONE) && (illegal_addr_s || read_only_s);
    assign trap_s      = exc_valid || (trap_take && irq_pending_s);
    assign csr_we_s    = (csr_op != CSR_OP_NONE) && !csr_illegal && !trap_s && !mret;
    assign wval_s      = csr_apply_op(csr_op_e'(csr_op), csr_rdata, csr_wdata);

    // interrupt arbiter: 11 > 3 > 7 > lowest-numbered local line
    always_comb begin
        pending_s    = mip_q & mie_q;
        local_code_s = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            local_code_s = pending_s[16+i] ? (IRQ_CODE_LOCAL0 + 5'(i)) : local_code_s;
        end
        if (pending_s[11]) begin
            irq_code_s = IRQ_CODE_MEI;
        end else if (pending_s[3]) begin
            irq_code_s = IRQ_CODE_MSI;
        end else if (pending_s[7]) begin
            irq_code_s = IRQ_CODE_MTI;
        end else begin
            irq_code_s = local_code_s;
        end
        irq_pending_s = mstatus_mie_q && (pending_s != 32'd0);
    end

    // architectural next state: trap beats mret beats a CSR write
    always_comb begin
        mstatus_mie_d   = mstatus_mie_q;
        mstatus_mpie_d  = mstatus_mpie_q;
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mscratch_d      = mscratch_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mtval_d         = mtval_q;
        mcountinhibit_d = mcountinhibit_q;
        mip_d           = {local_src_s, 4'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_soft, 3'd0};
        if (trap_s) begin
            mepc_d         = {current_pc[31:2], 2'b00};
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            if (exc_valid) begin
                mcause_d = {27'd0, exc_code};
                mtval_d  = exc_tval;
            end else begin
                mcause_d = {1'b1, 26'd0, irq_code_s};
                mtval_d  = 32'd0;
            end
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we_s) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wval_s[MSTATUS_MIE];
                    mstatus_mpie_d = wval_s[MSTATUS_MPIE];
                end
                CSR_MIE:           mie_d           = wval_s & MIE_MASK;
                CSR_MTVEC:         mtvec_d         = wval_s & 32'hFFFF_FFFD;
                CSR_MSCRATCH:      mscratch_d      = wval_s;
                CSR_MEPC:          mepc_d          = wval_s & 32'hFFFF_FFFC;
                CSR_MCAUSE:        mcause_d        = wval_s;
                CSR_MTVAL:         mtval_d         = wval_s;
                CSR_MCOUNTINHIBIT: mcountinhibit_d = wval_s & 32'h0000_0005;
                default:           mscratch_d      = mscratch_q;
            endcase
        end else begin
            mscratch_d = mscratch_q;
        end
    end

    // CSR state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= 32'd0;
            mtvec_q         <= MTVEC_RESET;
            mscratch_q      <= 32'd0;
            mepc_q          <= 32'd0;
            mcause_q        <= 32'd0;
            mtval_q         <= 32'd0;
            mip_q           <= 32'd0;
            mcountinhibit_q <= 32'd0;
        end else begin
            mstatus_mie_q   <= mstatus_mie_d;
            mstatus_mpie_q  <= mstatus_mpie_d;
            mie_q           <= mie_d;
            mtvec_q         <= mtvec_d;
            mscratch_q      <= mscratch_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mtval_q         <= mtval_d;
            mip_q           <= mip_d;
            mcountinhibit_q <= mcountinhibit_d;
        end
    end

    generate
        if (HAS_COUNTERS) begin : g_counters
            csr_counter64 u_mcycle (
                .clk     (clk),
                .rst_n   (reset_n),
                .en      (1'b1),
                .inhibit (mcountinhibit_q[0]),
                .wr_lo   (csr_we_s && (csr_addr == CSR_MCYCLE)),
                .wr_hi   (csr_we_s && (csr_addr == CSR_MCYCLEH)),
                .wdata   (wval_s),
                .count   (mcycle_s)
            );
            csr_counter64 u_minstret (
                .clk     (clk),
                .rst_n   (reset_n),
                .en      (instr_retire),
                .inhibit (mcountinhibit_q[2]),
                .wr_lo   (csr_we_s && (csr_addr == CSR_MINSTRET)),
                .wr_hi   (csr_we_s && (csr_addr == CSR_MINSTRETH)),
                .wdata   (wval_s),
                .count   (minstret_s)
            );
        end else begin : g_no_counters
            assign mcycle_s   = 64'd0;
            assign minstret_s = 64'd0;
        end
    endgenerate

    assign irq_pending = irq_pending_s;
    assign irq_code    = irq_code_s;
    assign mepc        = mepc_q;
    assign mie_global  = mstatus_mie_q;
    assign trap_vector = (mtvec_q[0] && !exc_valid)
                       ? ({mtvec_q[31:2], 2'b00} + {25'd0, irq_code_s, 2'b00})
                       : {mtvec_q[31:2], 2'b00};

endmodule

// File: tb/tb_csr_file_m.sv
// Scoreboard bench for csr_file_m: expectations are queued when stimulus is
// applied and popped against the DUT outputs when they are sampled.
module tb_csr_file_m;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata, csr_rdata, exc_tval, current_pc, trap_vector, mepc;
    logic        csr_illegal, irq_ext, irq_timer, irq_soft, irq_pending;
    logic [3:0]  irq_local;
    logic [4:0]  irq_code, exc_code;
    logic        trap_take, exc_valid, mret, instr_retire, mie_global;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    csr_file_m dut (
        .clk(clk), .reset_n(reset_n), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .irq_local(irq_local), .irq_pending(irq_pending), .irq_code(irq_code),
        .trap_take(trap_take), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_tval(exc_tval), .current_pc(current_pc), .mret(mret),
        .instr_retire(instr_retire), .trap_vector(trap_vector), .mepc(mepc),
        .mie_global(mie_global)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got %h expected nothing queued", obs);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
        csr_addr  = addr;
        csr_op    = op;
        csr_wdata = data;
        tick();
        csr_op    = 2'b00;
    endtask

    task automatic expect_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        sb_push(tag, exp);
        csr_addr = addr;
        csr_op   = 2'b00;
        #1;
        sb_pop_check(csr_rdata);
    endtask

    initial begin
        reset_n = 1'b0; csr_addr = 12'h000; csr_op = 2'b00; csr_wdata = 32'd0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0; irq_local = 4'd0;
        trap_take = 1'b0; exc_valid = 1'b0; exc_code = 5'd0; exc_tval = 32'd0;
        current_pc = 32'd0; mret = 1'b0; instr_retire = 1'b0;
        #22 reset_n = 1'b1;
        tick();

        // reset state
        expect_rd("rst_mstatus", 12'h300, 32'h0000_1800);
        expect_rd("rst_mtvec",   12'h305, 32'h0000_0000);
        expect_rd("rst_misa",    12'h301, 32'h4000_0100);
        sb_push("rst_irq_pending", 32'd0);
        sb_pop_check({31'd0, irq_pending});

        // basic writes and legality
        csr_write(12'h300, 2'b01, 32'h8);
        expect_rd("mstatus_wr", 12'h300, 32'h0000_1808);
        sb_push("mie_global", 32'd1);
        sb_pop_check({31'd0, mie_global});
        csr_addr = 12'h344; csr_op = 2'b10; csr_wdata = 32'hFFFF_FFFF;
        sb_push("mip_wr_legal", 32'd0);
        #1 sb_pop_check({31'd0, csr_illegal});
        tick(); csr_op = 2'b00;
        expect_rd("mip_ignored", 12'h344, 32'd0);
        csr_addr = 12'hF14; csr_op = 2'b01; csr_wdata = 32'h5;
        sb_push("hartid_illegal", 32'd1);
        #1 sb_pop_check({31'd0, csr_illegal});
        tick(); csr_op = 2'b00;
        expect_rd("hartid_rd", 12'hF14, 32'd0);
        csr_addr = 12'h7C0; csr_op = 2'b11; csr_wdata = 32'hFFFF_FFFF;
        sb_push("unimpl_illegal", 32'd1);
        #1 sb_pop_check({31'd0, csr_illegal});
        tick(); csr_op = 2'b00;
        expect_rd("mstatus_kept", 12'h300, 32'h0000_1808);

        // WARL masking
        csr_write(12'h305, 2'b01, 32'hFFFF_FFFF);
        expect_rd("mtvec_warl", 12'h305, 32'hFFFF_FFFD);
        csr_write(12'h341, 2'b01, 32'h0000_0123);
        expect_rd("mepc_warl", 12'h341, 32'h0000_0120);
        csr_write(12'h304, 2'b01, 32'hFFFF_FFFF);
        expect_rd("mie_warl", 12'h304, 32'h000F_0888);
        csr_write(12'h304, 2'b01, 32'h0000_0880);
        csr_write(12'h305, 2'b01, 32'h0);

        // ext + timer together: ext wins after one cycle of mip latency
        irq_timer = 1'b1; irq_ext = 1'b1;
        sb_push("pend_latency", 32'd0);
        #1 sb_pop_check({31'd0, irq_pending});
        tick();
        sb_push("pend_set", 32'd1);
        sb_pop_check({31'd0, irq_pending});
        sb_push("code_ext", 32'd11);
        sb_pop_check({27'd0, irq_code});
        trap_take = 1'b1; current_pc = 32'h100;
        tick();
        trap_take = 1'b0; irq_ext = 1'b0;
        expect_rd("irq_mepc",    12'h341, 32'h0000_0100);
        expect_rd("irq_mcause",  12'h342, 32'h8000_000B);
        expect_rd("irq_mstatus", 12'h300, 32'h0000_1880);

        // vectored mtvec, then exception beats interrupt
        csr_write(12'h305, 2'b01, 32'h2001);
        csr_write(12'h300, 2'b10, 32'h8);
        sb_push("code_timer", 32'd7);
        sb_pop_check({27'd0, irq_code});
        sb_push("vec_timer", 32'h0000_201C);
        sb_pop_check(trap_vector);
        exc_valid = 1'b1; exc_code = 5'd2; exc_tval = 32'hDEAD; trap_take = 1'b1; current_pc = 32'h200;
        sb_push("vec_exc", 32'h0000_2000);
        #1 sb_pop_check(trap_vector);
        tick();
        exc_valid = 1'b0; trap_take = 1'b0;
        expect_rd("exc_mcause",  12'h342, 32'h0000_0002);
        expect_rd("exc_mtval",   12'h343, 32'h0000_DEAD);
        expect_rd("exc_mepc",    12'h341, 32'h0000_0200);
        expect_rd("exc_mstatus", 12'h300, 32'h0000_1880);

        // mret, then mret colliding with a CSR clear
        mret = 1'b1;
        tick();
        mret = 1'b0;
        expect_rd("mret_mstatus", 12'h300, 32'h0000_1888);
        mret = 1'b1; csr_addr = 12'h300; csr_op = 2'b11; csr_wdata = 32'h88;
        tick();
        mret = 1'b0; csr_op = 2'b00;
        expect_rd("mret_drops_wr", 12'h300, 32'h0000_1888);

        // counters
        instr_retire = 1'b1;
        repeat (3) tick();
        instr_retire = 1'b0;
        expect_rd("minstret_3", 12'hB02, 32'd3);
        csr_write(12'hB80, 2'b01, 32'd0);
        csr_write(12'hB00, 2'b01, 32'hFFFF_FFFF);
        expect_rd("mcycle_wr",  12'hB00, 32'hFFFF_FFFF);
        expect_rd("mcycleh_wr", 12'hB80, 32'd0);
        tick();
        expect_rd("mcycle_wrap",  12'hB00, 32'd0);
        expect_rd("mcycleh_wrap", 12'hB80, 32'd1);
        csr_write(12'h320, 2'b01, 32'h5);
        expect_rd("inhibit_rd", 12'h320, 32'h5);
        instr_retire = 1'b1;
        repeat (10) tick();
        instr_retire = 1'b0;
        expect_rd("mcycle_hold",    12'hB00, 32'd1);
        expect_rd("mcycleh_hold",   12'hB80, 32'd1);
        expect_rd("minstret_hold",  12'hB02, 32'd3);
        expect_rd("minstreth_hold", 12'hB82, 32'd0);

        // asynchronous reset in the middle of a trap
        tick();
        sb_push("pre_rst_pending", 32'd1);
        sb_pop_check({31'd0, irq_pending});
        trap_take = 1'b1; current_pc = 32'h300;
        #1 reset_n = 1'b0;
        expect_rd("arst_mepc",   12'h341, 32'd0);
        expect_rd("arst_mcause", 12'h342, 32'd0);
        expect_rd("arst_mtvec",  12'h305, 32'd0);
        sb_push("arst_pending", 32'd0);
        #1 sb_pop_check({31'd0, irq_pending});
        trap_take = 1'b0; irq_timer = 1'b0;
        #3 reset_n = 1'b1;
        tick();
        expect_rd("post_rst_mstatus", 12'h300, 32'h0000_1800);

        check_val("sb_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
